// File: rtl/cog_ctrx.sv
// Cog counter with prescaler, period/pulse-width capture, one-shot mode and completion event.
// Optional glitch filter on the A/B pin paths is enabled by defining COG_CTRX_GLITCH_FILT_EN.
module cog_ctrx #(
  parameter int W        = 32,
  parameter int PINS     = 32,
  parameter int SEL_W    = 5,
  parameter int FILT_LEN = 3
) (
  input  logic            clk_cog,
  input  logic            ena,
  input  logic            setctr,
  input  logic            setfrq,
  input  logic            setphs,
  input  logic [W-1:0]    data,
  input  logic [PINS-1:0] pin_in,
  output logic [W:0]      phs,
  output logic [W-1:0]    cap,
  output logic            evt,
  output logic [PINS-1:0] pin_out
);

  logic [31:0]      r_ctr;
  logic [W-1:0]     r_frq;
  logic [W:0]       r_phs;
  logic [W-1:0]     r_cap;
  logic             r_evt;
  logic [14:0]      r_pre;
  logic             r_ctr_wr;
  logic             r_a_s1, r_a_s2, r_a_prev;
  logic             r_b_s1, r_b_s2, r_b_prev;

  logic [SEL_W-1:0] w_apin, w_bpin;
  logic [3:0]       w_div;
  logic [4:0]       w_mode;
  logic [14:0]      w_mask;
  logic             w_tick;
  logic             w_a_lvl, w_b_lvl;
  logic             w_pos_a, w_neg_a;
  logic [W-1:0]     w_lo;
  logic [W:0]       w_sum;
  logic [W:0]       w_phs_nxt;
  logic [W-1:0]     w_cap_nxt;
  logic             w_evt_nxt;
  logic             w_outa, w_outb;
  logic             w_unused;

  assign w_apin = r_ctr[SEL_W-1:0];
  assign w_bpin = r_ctr[8+SEL_W-1:8];
  assign w_div  = r_ctr[19:16];
  assign w_mode = r_ctr[28:24];

  assign w_mask = ~(15'h7fff << w_div);
  assign w_tick = (r_pre & w_mask) == w_mask;

`ifdef COG_CTRX_GLITCH_FILT_EN
  // Level follows s2 only once the last FILT_LEN samples agree; otherwise it holds.
  logic [FILT_LEN-2:0] r_a_hist, r_b_hist;
  logic                r_a_flt, r_b_flt;
  logic [FILT_LEN-1:0] w_a_win, w_b_win;

  assign w_a_win = {r_a_hist, r_a_s2};
  assign w_b_win = {r_b_hist, r_b_s2};
  assign w_a_lvl = (&w_a_win) ? 1'b1 : ((|w_a_win) ? r_a_flt : 1'b0);
  assign w_b_lvl = (&w_b_win) ? 1'b1 : ((|w_b_win) ? r_b_flt : 1'b0);

  always_ff @(posedge clk_cog or negedge ena) begin
    if (!ena) begin
      r_a_hist <= '0;
      r_b_hist <= '0;
      r_a_flt  <= 1'b0;
      r_b_flt  <= 1'b0;
    end else begin
      r_a_hist <= w_a_win[FILT_LEN-2:0];
      r_b_hist <= w_b_win[FILT_LEN-2:0];
      r_a_flt  <= w_a_lvl;
      r_b_flt  <= w_b_lvl;
    end
  end
`else
  assign w_a_lvl = r_a_s2;
  assign w_b_lvl = r_b_s2;
`endif

  // Edges are ignored for the cycle after a control write, while the pin selection settles.
  assign w_pos_a = w_a_lvl & ~r_a_prev & ~r_ctr_wr;
  assign w_neg_a = ~w_a_lvl & r_a_prev & ~r_ctr_wr;

  assign w_lo  = r_phs[W-1:0];
  assign w_sum = {1'b0, w_lo} + {1'b0, r_frq};

  always_comb begin
    w_phs_nxt = r_phs;
    w_cap_nxt = r_cap;
    w_evt_nxt = 1'b0;
    case (w_mode)
      5'd1, 5'd2, 5'd3, 5'd4, 5'd5: begin
        if (w_tick) begin
          w_phs_nxt = w_sum;
          w_evt_nxt = w_sum[W];
        end
      end
      5'd6, 5'd7:   if (w_tick && w_a_lvl)  w_phs_nxt = w_sum;
      5'd8, 5'd9:   if (w_tick && !w_a_lvl) w_phs_nxt = w_sum;
      5'd10:        if (w_pos_a) w_phs_nxt = w_sum;
      5'd11:        if (w_neg_a) w_phs_nxt = w_sum;
      5'd12: begin
        if (w_pos_a) begin
          w_cap_nxt = w_lo;
          w_phs_nxt = '0;
          w_evt_nxt = 1'b1;
        end else if (w_tick) begin
          w_phs_nxt = w_sum;
        end
      end
      5'd13: begin
        if (w_neg_a) begin
          w_cap_nxt = w_lo;
          w_phs_nxt = '0;
          w_evt_nxt = 1'b1;
        end else if (w_tick && w_a_lvl) begin
          w_phs_nxt = w_sum;
        end
      end
      5'd14: begin
        if (w_tick && (w_lo != '0)) begin
          if (r_frq >= w_lo) begin
            w_phs_nxt = '0;
            w_evt_nxt = 1'b1;
          end else begin
            w_phs_nxt = {1'b0, w_lo - r_frq};
          end
        end
      end
      default: ;
    endcase
    if (setphs) begin
      w_phs_nxt = {1'b0, data};
      w_cap_nxt = r_cap;
      w_evt_nxt = 1'b0;
    end
  end

  always_comb begin
    w_outa = 1'b0;
    w_outb = 1'b0;
    case (w_mode)
      5'd2:  w_outa = r_phs[W-1];
      5'd3: begin
        w_outa = r_phs[W-1];
        w_outb = ~r_phs[W-1];
      end
      5'd4:  w_outa = r_phs[W];
      5'd5: begin
        w_outa = r_phs[W];
        w_outb = ~r_phs[W];
      end
      5'd7:  w_outb = ~w_a_lvl;
      5'd9:  w_outb = w_a_lvl;
      5'd14: w_outa = (w_lo != '0);
      default: ;
    endcase
  end

  always_ff @(posedge clk_cog or negedge ena) begin
    if (!ena) begin
      r_ctr    <= '0;
      r_frq    <= '0;
      r_phs    <= '0;
      r_cap    <= '0;
      r_evt    <= 1'b0;
      r_pre    <= '0;
      r_ctr_wr <= 1'b0;
      r_a_s1   <= 1'b0;
      r_a_s2   <= 1'b0;
      r_a_prev <= 1'b0;
      r_b_s1   <= 1'b0;
      r_b_s2   <= 1'b0;
      r_b_prev <= 1'b0;
    end else begin
      if (setctr) r_ctr <= data[31:0];
      if (setfrq) r_frq <= data;
      r_phs    <= w_phs_nxt;
      r_cap    <= w_cap_nxt;
      r_evt    <= w_evt_nxt;
      r_pre    <= setctr ? 15'd0 : r_pre + 15'd1;
      r_ctr_wr <= setctr;
      r_a_s1   <= pin_in[w_apin];
      r_a_s2   <= r_a_s1;
      r_a_prev <= w_a_lvl;
      r_b_s1   <= pin_in[w_bpin];
      r_b_s2   <= r_b_s1;
      r_b_prev <= w_b_lvl;
    end
  end

  assign phs     = r_phs;
  assign cap     = r_cap;
  assign evt     = r_evt;
  assign pin_out = ({{(PINS-1){1'b0}}, w_outb} << w_bpin) |
                   ({{(PINS-1){1'b0}}, w_outa} << w_apin);

  // B is synchronised alongside A but no current mode consumes its level.
  assign w_unused = ^{r_ctr[31:29], r_ctr[23:20], r_ctr[15:8+SEL_W], r_ctr[7:SEL_W], r_b_prev};

endmodule
